ring_osc_freq_meter: RTL and testbench
======================================

Name: ring_osc_freq_meter

Overview:
- Multi-channel on-chip frequency meter for free-running ring-oscillator outputs.
- Selects one of N_CH oscillator inputs and divides it by 2^PRE_LOG2 with an asynchronous prescaler clocked in the oscillator domain.
- Counts prescaled rising edges in the clk domain over a programmable gate window of clk cycles.
- Sits beside the ring oscillator instances; its result replaces direct pad observation of raw oscillator outputs.

Parameters:
- N_CH, 4, number of oscillator inputs.
- PRE_LOG2, 3, prescaler stages; prescale ratio = 2^PRE_LOG2.
- CNT_W, 16, width of the result counter.
- WIN_LOG2_MIN, 8, log2 of the shortest gate window in clk cycles.
- WIN_SEL_W, 2, width of win_sel; window = 2^(WIN_LOG2_MIN+win_sel) cycles.
- SETTLE_CYC, 4, clk cycles discarded after channel latch (synchroniser flush).

Ports:
- clk  in  1  measurement reference clock.
- rst_n  in  1  asynchronous active-low reset, clears all state including prescalers.
- osc_in  in  N_CH  raw oscillator outputs, asynchronous to clk.
- ch_sel  in  $clog2(N_CH)  channel to measure, sampled on accepted start.
- win_sel  in  WIN_SEL_W  window select, sampled on accepted start.
- start  in  1  one-cycle request to begin a measurement.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- count  out  CNT_W  prescaled edge count of the last measurement.
- overflow  out  1  count saturated during the last measurement.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, count=0, overflow=0; FSM in IDLE; all prescalers and synchronisers cleared.
- Prescaler:
  - One PRE_LOG2-bit ripple/binary counter per channel, clocked by osc_in[i] and asynchronously cleared by rst_n.
  - Its MSB (pre_msb[i]) toggles once every 2^(PRE_LOG2-1) oscillator cycles.
  - PRE_LOG2=0 passes osc_in straight through.
- Mux and synchroniser:
  - pre_msb[ch_q] goes through a 2-flop synchroniser into clk, plus a third flop for rising-edge detection.
  - An edge pulse is valid only while the selected prescaled frequency is below clk/2; the integrator chooses PRE_LOG2 to guarantee this.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
  - IDLE: start=1 latches ch_q=ch_sel and win_q=win_sel, clears count and overflow, and goes to SETTLE. busy rises the next cycle.
  - SETTLE: waits exactly SETTLE_CYC cycles with edges ignored, then goes to MEASURE with the window counter loaded to 2^(WIN_LOG2_MIN+win_q)-1.
  - MEASURE:
    - Each detected edge increments count.
    - At count = 2^CNT_W-1, count holds and overflow sets and stays set.
    - The window counter decrements every cycle; when it reaches 0 (a window of exactly 2^(WIN_LOG2_MIN+win_q) cycles), go to DONE. An edge in that final cycle is counted.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, then return to IDLE.
- Result hold: count and overflow keep their values through IDLE until the next accepted start.
- start while busy (SETTLE, MEASURE or DONE) is ignored, with no queueing.
- ch_sel and win_sel changes outside an accepted start have no effect.
- Latency: start to done = 1 + SETTLE_CYC + 2^(WIN_LOG2_MIN+win_sel) + 1 clk cycles.
- Measured frequency f_osc ≈ count·2^PRE_LOG2·f_clk / window.
  - Quantisation is ±1 count.
  - Edge detect of the MSB rise gives one edge per 2^PRE_LOG2 oscillator cycles.
- rst_n asserted mid-measurement: immediate abort to the reset values with no done pulse. After release, the block is in IDLE and ready for start.
- An oscillator input stuck at 0 or 1 yields count=0, overflow=0, with done still pulsing on time.

Test Plan:
- Reset and idle check:
  - Stimulus: reset asserted mid-MEASURE (clk 20 ns, osc_in[1] period 10 ns, start with ch_sel=1, win_sel=0, rst_n low at cycle 100).
  - Required: busy/done/count/overflow=0 immediately, no done pulse; a fresh start afterwards completes normally.
- Basic measurement:
  - Stimulus: clk 20 ns, osc_in[1] period 10 ns, defaults, ch_sel=1, win_sel=0, start.
  - Required: done exactly 262 cycles after start; count = 64±1; overflow=0; busy high for cycles 1..261.
- Window scaling:
  - Stimulus: same oscillator, win_sel=2.
  - Required: done at 1030 cycles; count = 256±1.
- Channel independence:
  - Stimulus: osc_in[0] period 40 ns, osc_in[3] stuck 0; measure ch 0 then ch 3 with win_sel=0.
  - Required: ch0 count = 16±1; ch3 count = 0, done still pulses.
- Saturation:
  - Stimulus: CNT_W=6, osc_in[2] period 10 ns, win_sel=3 (2048-cycle window, ~512 edges).
  - Required: count = 63, overflow=1, both held in IDLE until the next start.
- Start while busy:
  - Stimulus: start pulsed again at cycle 50 of a measurement with ch_sel changed.
  - Required: ignored; the original channel's result appears at the original done time, with exactly one done pulse.

Source files
------------

// File: rtl/ring_osc_freq_meter.sv
// Purpose : multi-channel ring-oscillator frequency meter; counts prescaled osc edges over a gate window of clk cycles.
// Latency : start to done = 1 + SETTLE_CYC + 2^(WIN_LOG2_MIN+win_sel) + 1 clk cycles.
// Backpressure: none; start is ignored (not queued) while a measurement is in flight.
// Ports   : clk/rst_n reference clock and async active-low reset; osc_in raw oscillator outputs (async to clk);
//           ch_sel/win_sel channel and window, sampled on an accepted start; start one-cycle request;
//           busy/done status (done is a one-cycle pulse); count/overflow result held until the next start.
module ring_osc_freq_meter #(
    parameter int N_CH         = 4,
    parameter int PRE_LOG2     = 3,
    parameter int CNT_W        = 16,
    parameter int WIN_LOG2_MIN = 8,
    parameter int WIN_SEL_W    = 2,
    parameter int SETTLE_CYC   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          osc_in,
    input  logic [$clog2(N_CH)-1:0]  ch_sel,
    input  logic [WIN_SEL_W-1:0]     win_sel,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);

    // Window counter must hold 2^(largest window log2) - 1.
    localparam int WIN_W    = WIN_LOG2_MIN + (1 << WIN_SEL_W) - 1;
    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t                    state;
    logic [$clog2(N_CH)-1:0]   ch_q;
    logic [WIN_SEL_W-1:0]      win_q;
    logic [SETTLE_W-1:0]       settle_cnt;
    logic [WIN_W-1:0]          win_cnt;
    logic [WIN_W-1:0]          win_load;
    logic [N_CH-1:0]           pre_msb;
    logic [2:0]                sync;
    logic                      edge_pulse;

    // Per-channel prescaler running in its own oscillator domain. Reset is the only
    // clk-side control it sees, so an unselected oscillator can keep running freely.
    for (genvar i = 0; i < N_CH; i++) begin : g_pre
        if (PRE_LOG2 == 0) begin : g_thru
            assign pre_msb[i] = osc_in[i];
        end else begin : g_div
            logic [PRE_LOG2-1:0] div;
            always_ff @(posedge osc_in[i] or negedge rst_n) begin
                if (!rst_n) begin
                    div <= '0;
                end else begin
                    div <= div + 1'b1;
                end
            end
            assign pre_msb[i] = div[PRE_LOG2-1];
        end
    end

    // Two synchroniser flops plus one history flop for rising-edge detection.
    // The mux ahead of the first flop switches only on an accepted start; the
    // SETTLE phase discards whatever glitch that switch pushes through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], pre_msb[ch_q]};
        end
    end

    assign edge_pulse = sync[1] & ~sync[2];

    // Window reload value 2^(WIN_LOG2_MIN+win_q)-1: all bits below the window log2 set.
    always_comb begin
        win_load = '0;
        for (int b = 0; b < WIN_W; b++) begin
            win_load[b] = (b < (WIN_LOG2_MIN + int'(win_q)));
        end
    end

    // busy/done are registered, so the DONE state is still seen as busy and the
    // done pulse lands one cycle later, coinciding with busy falling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ch_q       <= '0;
            win_q      <= '0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch_q       <= ch_sel;
                        win_q      <= win_sel;
                        count      <= '0;
                        overflow   <= 1'b0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        win_cnt <= win_load;
                        state   <= S_MEASURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    // Overflow flags an edge that arrived with the counter already full.
                    if (edge_pulse) begin
                        if (count == CNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    if (win_cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench for ring_osc_freq_meter: a default-width instance plus a 6-bit-count
// instance sharing all inputs. clk 20 ns; osc0 40 ns, osc1/osc2 10 ns, osc3 stuck low.
// Oscillators are phase-offset so their edges never coincide with clk edges.
module tb_ring_osc_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        osc0, osc1, osc2;
    logic [3:0]  osc_in;
    logic [1:0]  ch_sel;
    logic [1:0]  win_sel;
    logic        start;

    logic        busy, done, overflow;
    logic [15:0] count;
    logic        busy_s, done_s, ov_s;
    logic [5:0]  count_s;

    int n_chk  = 0;
    int n_pass = 0;

    assign osc_in = {1'b0, osc2, osc1, osc0};

    ring_osc_freq_meter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .osc_in   (osc_in),
        .ch_sel   (ch_sel),
        .win_sel  (win_sel),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    ring_osc_freq_meter #(.CNT_W(6)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .osc_in   (osc_in),
        .ch_sel   (ch_sel),
        .win_sel  (win_sel),
        .start    (start),
        .busy     (busy_s),
        .done     (done_s),
        .count    (count_s),
        .overflow (ov_s)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        osc0 = 1'b0;
        #3;
        forever #20 osc0 = ~osc0;
    end

    initial begin
        osc1 = 1'b0;
        #3;
        forever #5 osc1 = ~osc1;
    end

    initial begin
        osc2 = 1'b0;
        #4;
        forever #5 osc2 = ~osc2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        n_chk++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    // Issue one start and follow the run. lat = cycle index of the first done
    // (start edge = cycle 0), or 0 if done never came within the budget.
    task automatic measure(input logic [1:0] ch, input logic [1:0] win,
                           input int restart_at, input logic [1:0] restart_ch,
                           output int lat, output int n_done, output bit busy_ok);
        @(negedge clk);
        ch_sel  = ch;
        win_sel = win;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        ch_sel  = ch + 2'd1;
        win_sel = win ^ 2'd1;
        lat     = 0;
        n_done  = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            if (c == restart_at) begin
                start  = 1'b1;
                ch_sel = restart_ch;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                n_done++;
                if (lat == 0) lat = c;
            end
            if (lat == 0 && busy !== 1'b1) busy_ok = 1'b0;
            if (lat != 0 && busy !== 1'b0) busy_ok = 1'b0;
            if (lat != 0 && c >= lat + 20) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int lat, n_done;
    bit busy_ok;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        ch_sel  = 2'd0;
        win_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        chk("rst_count",    count,    0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic measurement: osc1 80 ns prescaled period, 256-cycle window -> 64 edges.
        measure(2'd1, 2'd0, 0, 2'd0, lat, n_done, busy_ok);
        chk("basic_latency", lat, 262);
        chk("basic_ndone",   n_done, 1);
        chk("basic_busy",    busy_ok, 1);
        chk_rng("basic_count", count, 63, 65);
        chk("basic_ovf",     overflow, 0);
        // Result held in IDLE while selects wander.
        ch_sel  = 2'd3;
        win_sel = 2'd3;
        repeat (30) @(negedge clk);
        chk_rng("hold_count", count, 63, 65);
        chk("hold_busy", busy, 0);

        // Window scaling: 1024-cycle window -> 256 edges.
        measure(2'd1, 2'd2, 0, 2'd0, lat, n_done, busy_ok);
        chk("win2_latency", lat, 1030);
        chk("win2_busy",    busy_ok, 1);
        chk_rng("win2_count", count, 255, 257);

        // Channel independence: osc0 320 ns prescaled period -> 16 edges; osc3 stuck.
        measure(2'd0, 2'd0, 0, 2'd0, lat, n_done, busy_ok);
        chk("ch0_latency", lat, 262);
        chk_rng("ch0_count", count, 15, 17);
        measure(2'd3, 2'd0, 0, 2'd0, lat, n_done, busy_ok);
        chk("ch3_latency", lat, 262);
        chk("ch3_ndone",   n_done, 1);
        chk("ch3_count",   count, 0);
        chk("ch3_ovf",     overflow, 0);

        // Saturation: 2048-cycle window on osc2 gives ~512 edges.
        measure(2'd2, 2'd3, 0, 2'd0, lat, n_done, busy_ok);
        chk("sat_latency", lat, 2054);
        chk("sat_count6",  count_s, 63);
        chk("sat_ovf6",    ov_s, 1);
        chk_rng("sat_count16", count, 511, 513);
        chk("sat_ovf16",   overflow, 0);
        repeat (100) @(negedge clk);
        chk("sat_hold_count", count_s, 63);
        chk("sat_hold_ovf",   ov_s, 1);

        // Start while busy at cycle 50 pointing at ch0: must be ignored.
        measure(2'd1, 2'd0, 50, 2'd0, lat, n_done, busy_ok);
        chk("rebusy_latency", lat, 262);
        chk("rebusy_ndone",   n_done, 1);
        chk_rng("rebusy_count", count, 63, 65);

        // Reset mid-MEASURE at cycle 100.
        @(negedge clk);
        ch_sel  = 2'd1;
        win_sel = 2'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        chk_rng("pre_rst_count", count, 1, 65);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",     busy,     0);
        chk("midrst_done",     done,     0);
        chk("midrst_count",    count,    0);
        chk("midrst_overflow", overflow, 0);
        n_done = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 4) rst_n = 1'b1;
            if (done === 1'b1) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        measure(2'd1, 2'd0, 0, 2'd0, lat, n_done, busy_ok);
        chk("postrst_latency", lat, 262);
        chk("postrst_busy",    busy_ok, 1);
        chk_rng("postrst_count", count, 63, 65);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
